fetch_pc_ctrl: RTL and testbench

//  PC register and instruction-fetch sequencer for the sequential core.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_pc_ctrl_mux2.sv | 13 +
 rtl/fetch_pc_ctrl.sv | 130 +++++++++++++
 tb/tb_fetch_pc_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

  localparam int INST_W = 32;
  localparam logic [INST_W-1:0] INST_NOP = 32'h00000013;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    ERR  = 2'd3
  } state_t;

  // Instruction addresses must sit on a 4-byte boundary.
  function automatic logic is_aligned(input logic [1:0] lsbs);
    return lsbs == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_pc_ctrl_mux2.sv
// Two-input mux used as the next-PC selector (a when sel=0, b when sel=1).
module mux2 #(
  parameter int WIDTH = 64
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/fetch_pc_ctrl.sv
// PC register and single-outstanding instruction-fetch sequencer.
// Issues one request at a time, latches the returned word with its PC,
// and squashes responses that a branch/jump redirect has made stale.
module fetch_pc_ctrl
  import fetch_pkg::*;
#(
  parameter int              XLEN         = 64,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_target,
  input  logic              stall,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [XLEN-1:0]   imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst_out,
  output logic [XLEN-1:0]   inst_pc,
  output logic              misaligned_exc
);

  state_t          state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pend_target;
  logic            kill;

  logic [XLEN-1:0] pc_seq;
  logic [XLEN-1:0] pc_next;
  logic            slot_full;
  logic            req_fire;
  logic            redir_ok;
  logic            redir_bad;

  // Sequential successor wraps naturally modulo 2^XLEN.
  assign pc_seq = pc + XLEN'(4);

  mux2 #(.WIDTH(XLEN)) u_pc_mux (
    .sel (redirect_valid),
    .a   (pc_seq),
    .b   (redirect_target),
    .y   (pc_next)
  );

  assign redir_bad = redirect_valid & ~is_aligned(redirect_target[1:0]);
  assign redir_ok  = redirect_valid & ~redir_bad;

  // NOTE: the request is gated by the live stall so that nothing is accepted
  // while the output slot is held; the response could otherwise overwrite it.
  // Within REQ the slot can only drain, so a raised valid never drops early.
  assign slot_full      = inst_valid & stall;
  assign imem_req_valid = (state == REQ) & ~slot_full;
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid & imem_req_ready;

  // Fetch FSM, PC, kill/pending-target tracking and the output slot.
  // NOTE: all state uses non-blocking assignments; a later assignment in the
  // same block (e.g. loading inst_valid) deliberately overrides the default.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= BOOT;
      pc             <= RESET_VECTOR;
      pend_target    <= '0;
      kill           <= 1'b0;
      inst_valid     <= 1'b0;
      inst_out       <= INST_NOP;
      inst_pc        <= '0;
      misaligned_exc <= 1'b0;
    end else begin
      // Slot drains when downstream takes it; a redirect always flushes it.
      if (redirect_valid || !stall) begin
        inst_valid <= 1'b0;
      end

      if (redir_bad) begin
        state          <= ERR;
        misaligned_exc <= 1'b1;
        kill           <= 1'b0;
      end else begin
        case (state)
          BOOT: begin
            if (redir_ok) pc <= pc_next;
            state <= REQ;
          end
          REQ: begin
            if (req_fire) begin
              state <= WAIT;
              if (redir_ok) begin
                kill        <= 1'b1;
                pend_target <= redirect_target;
              end
            end else if (redir_ok) begin
              pc <= pc_next;
            end
          end
          WAIT: begin
            if (imem_rsp_valid) begin
              state <= REQ;
              kill  <= 1'b0;
              if (redir_ok) begin
                pc <= pc_next;
              end else if (kill) begin
                pc <= pend_target;
              end else begin
                inst_valid <= 1'b1;
                inst_out   <= imem_rsp_data;
                inst_pc    <= pc;
                pc         <= pc_next;
              end
            end else if (redir_ok) begin
              kill        <= 1'b1;
              pend_target <= redirect_target;
            end
          end
          ERR: begin
            if (redir_ok) begin
              pc             <= pc_next;
              misaligned_exc <= 1'b0;
              state          <= REQ;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed bench for fetch_pc_ctrl: boot, back-pressure, stale-response kill,
// output stall, misaligned redirect, mid-transaction reset and PC wrap.
module tb_fetch_pc_ctrl;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;
  logic            stall;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            inst_valid;
  logic [31:0]     inst_out;
  logic [XLEN-1:0] inst_pc;
  logic            misaligned_exc;

  int errors = 0;
  int checks = 0;

  fetch_pc_ctrl #(.XLEN(XLEN), .RESET_VECTOR(64'h0)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .stall           (stall),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .inst_valid      (inst_valid),
    .inst_out        (inst_out),
    .inst_pc         (inst_pc),
    .misaligned_exc  (misaligned_exc)
  );

  always #5 clk = ~clk;

  // Instruction word the bench's memory returns for a given address.
  function automatic logic [31:0] dw(input logic [63:0] a);
    return 32'hC0DE_0000 ^ a[31:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_target = '0; stall = 1'b0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;

    // Reset values
    @(posedge clk); #1;
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_req_addr", imem_req_addr, 64'h0);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_inst_out", inst_out, 32'h00000013);
    chk("rst_inst_pc", inst_pc, 64'h0);
    chk("rst_exc", misaligned_exc, 0);

    // 1: boot then sequential fetch, 1-cycle response latency
    @(negedge clk); rst_n = 1'b1; imem_req_ready = 1'b1;
    #1 chk("boot_no_req", imem_req_valid, 0);
    step(); #1;
    chk("req0_valid", imem_req_valid, 1);
    chk("req0_addr", imem_req_addr, 64'h0);
    step(); imem_rsp_valid = 1'b1; imem_rsp_data = dw(64'h0); #1;
    chk("wait0_no_req", imem_req_valid, 0);
    step(); imem_rsp_valid = 1'b0; #1;
    chk("i0_valid", inst_valid, 1);
    chk("i0_pc", inst_pc, 64'h0);
    chk("i0_data", inst_out, dw(64'h0));
    chk("req4_addr", imem_req_addr, 64'h4);
    chk("req4_valid", imem_req_valid, 1);
    step(); imem_rsp_valid = 1'b1; imem_rsp_data = dw(64'h4); #1;
    chk("i0_cleared", inst_valid, 0);

    // 2: ready low for 3 cycles while requesting 0x8
    step(); imem_rsp_valid = 1'b0; imem_req_ready = 1'b0; #1;
    chk("i4_valid", inst_valid, 1);
    chk("i4_pc", inst_pc, 64'h4);
    chk("bp_addr_a", imem_req_addr, 64'h8);
    for (int i = 0; i < 2; i++) begin
      step(); #1;
      chk("bp_valid", imem_req_valid, 1);
      chk("bp_addr", imem_req_addr, 64'h8);
    end
    step(); imem_req_ready = 1'b1; #1;
    chk("bp_accept_addr", imem_req_addr, 64'h8);

    // 3: redirect to 0x100 while waiting for 0x8
    step(); redirect_valid = 1'b1; redirect_target = 64'h100; #1;
    chk("wait8_no_req", imem_req_valid, 0);
    step(); redirect_valid = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = dw(64'h8); #1;
    chk("kill_no_inst", inst_valid, 0);
    step(); imem_rsp_valid = 1'b0; #1;
    chk("killed_no_inst", inst_valid, 0);
    chk("redir_req_valid", imem_req_valid, 1);
    chk("redir_req_addr", imem_req_addr, 64'h100);
    step(); imem_rsp_valid = 1'b1; imem_rsp_data = dw(64'h100);

    // 4: stall held 4 cycles with a valid instruction
    step(); imem_rsp_valid = 1'b0; stall = 1'b1; #1;
    chk("i100_valid", inst_valid, 1);
    chk("i100_pc", inst_pc, 64'h100);
    chk("i100_data", inst_out, dw(64'h100));
    chk("stall_no_req", imem_req_valid, 0);
    for (int i = 0; i < 3; i++) begin
      step(); #1;
      chk("stall_hold_valid", inst_valid, 1);
      chk("stall_hold_pc", inst_pc, 64'h100);
      chk("stall_hold_req", imem_req_valid, 0);
    end
    step(); stall = 1'b0; #1;
    chk("resume_valid", imem_req_valid, 1);
    chk("resume_addr", imem_req_addr, 64'h104);

    // 5: misaligned redirect, stray response in ERR, aligned recovery
    step(); redirect_valid = 1'b1; redirect_target = 64'h102; #1;
    chk("pre_err_inst", inst_valid, 0);
    step(); redirect_valid = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = dw(64'h104); #1;
    chk("err_exc", misaligned_exc, 1);
    chk("err_no_req", imem_req_valid, 0);
    step(); imem_rsp_valid = 1'b0; redirect_valid = 1'b1; redirect_target = 64'h200; #1;
    chk("err_exc_held", misaligned_exc, 1);
    chk("err_rsp_ignored", inst_valid, 0);
    step(); redirect_valid = 1'b0; #1;
    chk("recover_exc", misaligned_exc, 0);
    chk("recover_valid", imem_req_valid, 1);
    chk("recover_addr", imem_req_addr, 64'h200);

    // 6: reset while waiting for 0x200
    step(); #1; rst_n = 1'b0; #1;
    chk("mid_rst_req_valid", imem_req_valid, 0);
    chk("mid_rst_addr", imem_req_addr, 64'h0);
    chk("mid_rst_inst_out", inst_out, 32'h00000013);
    chk("mid_rst_inst_pc", inst_pc, 64'h0);
    chk("mid_rst_exc", misaligned_exc, 0);
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1; imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEADBEEF;
    #1 chk("reboot_no_req", imem_req_valid, 0);
    step(); imem_rsp_valid = 1'b0; #1;
    chk("reboot_stray_ignored", inst_valid, 0);
    chk("reboot_addr", imem_req_addr, 64'h0);
    chk("reboot_valid", imem_req_valid, 1);
    step(); imem_rsp_valid = 1'b1; imem_rsp_data = dw(64'h0);

    // PC wrap: withdraw an unaccepted request toward the top of memory
    step(); imem_rsp_valid = 1'b0; imem_req_ready = 1'b0;
    redirect_valid = 1'b1; redirect_target = 64'hFFFF_FFFF_FFFF_FFFC; #1;
    chk("reboot_i0_pc", inst_pc, 64'h0);
    chk("reboot_i0_data", inst_out, dw(64'h0));
    chk("pre_withdraw_addr", imem_req_addr, 64'h4);
    step(); redirect_valid = 1'b0; imem_req_ready = 1'b1; #1;
    chk("withdraw_inst_flushed", inst_valid, 0);
    chk("top_addr", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    step(); imem_rsp_valid = 1'b1; imem_rsp_data = dw(64'hFFFF_FFFF_FFFF_FFFC);
    step(); imem_rsp_valid = 1'b0; #1;
    chk("top_inst_pc", inst_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("top_inst_valid", inst_valid, 1);
    chk("wrap_addr", imem_req_addr, 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
